// File: rtl/apb_alu_ctrl_if.sv
// APB slave bus bundle for the ALU sequencer.
// Master drives the request, slave returns data/ready/error.
interface apb_alu_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_alu_ctrl.sv
// APB controller sequencing the shared ALU: operands, launch, settle, capture.
// Optional IRQ output and IRQ_EN register enabled by APB_ALU_CTRL_IRQ_EN.
module apb_alu_ctrl #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  apb_alu_ctrl_if.slave apb,
  output logic [31:0]  ALU_A,
  output logic [31:0]  ALU_B,
  output logic [7:0]   ALU_FUN,
  input  logic [31:0]  ALU_OUT
`ifdef APB_ALU_CTRL_IRQ_EN
  ,
  output logic         IRQ
`endif
);

  localparam int AW = ADDR_W - 2;
  localparam logic [3:0] CNT0 = 4'(LATENCY - 1);

  typedef enum logic {IDLE, EXEC} st_t;

  st_t         state, nstate;
  logic [3:0]  cnt;
  logic [31:0] a_reg, b_reg, res;
  logic [7:0]  fun;
  logic        done, div0, badfun;
  logic        busy, cap;
  logic        acc, wr, err, mapped;
  logic        launch, clr;
  logic        div0_c, bad_c;
  logic        s_a, s_b, s_f, s_c, s_s, s_r, s_i;
  logic [AW-1:0] widx;
  logic        unused_lsb;
`ifdef APB_ALU_CTRL_IRQ_EN
  logic        irq_en;
`endif

  assign widx       = apb.PADDR[ADDR_W-1:2];
  assign unused_lsb = ^apb.PADDR[1:0];
  assign acc        = apb.PSEL & apb.PENABLE;
  assign busy       = (state == EXEC);
  assign cap        = busy && (cnt == 4'd0);
  assign div0_c     = (fun == 8'h03) && (b_reg == 32'd0);
  assign bad_c      = (fun > 8'h0C);

  assign ALU_A   = a_reg;
  assign ALU_B   = b_reg;
  assign ALU_FUN = fun;

  // Address decode, error/stall detection and read mux
  always_comb begin
    s_a = (widx == AW'(0));
    s_b = (widx == AW'(1));
    s_f = (widx == AW'(2));
    s_c = (widx == AW'(3));
    s_s = (widx == AW'(4));
    s_r = (widx == AW'(5));
`ifdef APB_ALU_CTRL_IRQ_EN
    s_i = (widx == AW'(6));
`else
    s_i = 1'b0;
`endif
    mapped = s_a | s_b | s_f | s_c | s_s | s_r | s_i;
    err = !mapped
        | (apb.PWRITE & (s_s | s_r))
        | (apb.PWRITE & busy & (s_a | s_b | s_f | s_c));
    apb.PREADY  = !(acc & !apb.PWRITE & s_r & busy);
    apb.PSLVERR = acc & err;
    apb.PRDATA  = 32'd0;
    if (acc && !err) begin
      unique case (1'b1)
        s_a: apb.PRDATA = a_reg;
        s_b: apb.PRDATA = b_reg;
        s_f: apb.PRDATA = {24'd0, fun};
        s_s: apb.PRDATA = {28'd0, badfun, div0, done, busy};
        s_r: apb.PRDATA = res;
`ifdef APB_ALU_CTRL_IRQ_EN
        s_i: apb.PRDATA = {31'd0, irq_en};
`endif
        default: apb.PRDATA = 32'd0;
      endcase
    end
  end

  assign wr     = acc & apb.PREADY & apb.PWRITE & !err;
  assign launch = wr & s_c & apb.PWDATA[0];
  assign clr    = wr & s_c & apb.PWDATA[1];

  // Exec state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= nstate;
  end

  // Exec next state: launch on START, return on capture
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (launch) nstate = EXEC;
      EXEC: if (cnt == 4'd0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Register file, settle counter and result capture
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_reg  <= '0;
      b_reg  <= '0;
      fun    <= '0;
      res    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
      badfun <= 1'b0;
    end else begin
      if (wr && s_a) a_reg <= apb.PWDATA;
      if (wr && s_b) b_reg <= apb.PWDATA;
      if (wr && s_f) fun   <= apb.PWDATA[7:0];
      if (clr || launch) begin
        done   <= 1'b0;
        div0   <= 1'b0;
        badfun <= 1'b0;
      end
      if (launch)
        cnt <= CNT0;
      else if (busy && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (cap) begin
        res    <= (div0_c | bad_c) ? 32'd0 : ALU_OUT;
        done   <= 1'b1;
        div0   <= div0_c;
        badfun <= bad_c;
      end
    end
  end

`ifdef APB_ALU_CTRL_IRQ_EN
  // Interrupt enable and registered interrupt line
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      irq_en <= 1'b0;
      IRQ    <= 1'b0;
    end else begin
      if (wr && s_i) irq_en <= apb.PWDATA[0];
      IRQ <= done & irq_en;
    end
  end
`endif

endmodule

// File: tb/tb_apb_alu_ctrl.sv
// Scoreboarded random test of apb_alu_ctrl against a cycle-level model.
// Build with APB_ALU_CTRL_IRQ_EN to cover the interrupt path.
module tb_apb_alu_ctrl;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] ALU_A, ALU_B, ALU_OUT;
  logic [7:0]  ALU_FUN;
`ifdef APB_ALU_CTRL_IRQ_EN
  logic        IRQ;
`endif

  apb_alu_ctrl_if #(.ADDR_W(8)) bus();

  apb_alu_ctrl #(.LATENCY(LAT), .ADDR_W(8)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .apb(bus),
    .ALU_A(ALU_A),
    .ALU_B(ALU_B),
    .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT)
`ifdef APB_ALU_CTRL_IRQ_EN
    ,
    .IRQ(IRQ)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks = 0;
  int errors = 0;
  int nid = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    bit          chk;
    int          id;
    logic [7:0]  ad;
  } exp_t;
  exp_t q[$];
  exp_t mx;

  // ALU stand-in; 0x03 with B=0 and bad codes give junk the DUT must hide
  function automatic logic [31:0] alu(logic [31:0] a, logic [31:0] b,
                                      logic [7:0] f);
    case (f)
      8'h00: return a + b;
      8'h01: return a - b;
      8'h02: return a * b;
      8'h03: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      8'h04: return a & b;
      8'h05: return a | b;
      8'h06: return a ^ b;
      8'h07: return a << b[4:0];
      8'h08: return a >> b[4:0];
      8'h09: return ~a;
      8'h0A: return (a < b) ? 32'd1 : 32'd0;
      8'h0B: return {a[15:0], a[31:16]};
      8'h0C: return a + 32'd1;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign ALU_OUT = alu(ALU_A, ALU_B, ALU_FUN);

  // Reference model: registers plus launch edge of the last operation
  logic [31:0] m_a, m_b, m_res;
  logic [7:0]  m_fun;
  logic        m_ien, m_div0, m_bad;
  int          m_l;

  task automatic m_reset();
    m_a = 0; m_b = 0; m_res = 0; m_fun = 0;
    m_ien = 0; m_div0 = 0; m_bad = 0; m_l = -1;
  endtask

  function automatic bit m_busy(int t);
    return (m_l >= 0) && (t < m_l + LAT);
  endfunction

  function automatic logic [31:0] m_status(int t);
    if (m_l < 0) return 32'd0;
    if (t < m_l + LAT) return 32'd1;
    return {28'd0, m_bad, m_div0, 1'b1, 1'b0};
  endfunction

  function automatic bit wr_err(logic [7:0] w, int t);
    case (w)
      8'h00, 8'h04, 8'h08, 8'h0C: return m_busy(t);
`ifdef APB_ALU_CTRL_IRQ_EN
      8'h18: return 1'b0;
`endif
      default: return 1'b1;
    endcase
  endfunction

  task automatic rd_exp(input logic [7:0] w, input int t,
                        output logic [31:0] d, output logic e);
    e = 1'b0;
    d = 32'd0;
    case (w)
      8'h00: d = m_a;
      8'h04: d = m_b;
      8'h08: d = {24'd0, m_fun};
      8'h0C: d = 32'd0;
      8'h10: d = m_status(t);
      8'h14: d = m_res;
`ifdef APB_ALU_CTRL_IRQ_EN
      8'h18: d = {31'd0, m_ien};
`endif
      default: e = 1'b1;
    endcase
  endtask

  task automatic m_write(input logic [7:0] w, input logic [31:0] wd,
                         input int c);
    case (w)
      8'h00: m_a = wd;
      8'h04: m_b = wd;
      8'h08: m_fun = wd[7:0];
      8'h18: m_ien = wd[0];
      8'h0C: begin
        if (wd[1]) m_l = -1;
        if (wd[0]) begin
          m_l = c;
          m_div0 = (m_fun == 8'h03) && (m_b == 0);
          m_bad = (m_fun > 8'h0C);
          m_res = (m_div0 || m_bad) ? 32'd0 : alu(m_a, m_b, m_fun);
        end
      end
      default: ;
    endcase
  endtask

  // One APB transfer; caller sits 1 time unit after a rising edge
  task automatic apb(input bit wr, input logic [7:0] ad,
                     input logic [31:0] wd);
    exp_t x;
    int t;
    int n;
    bit ok;
    logic [7:0] w;
    t = cyc + 1;
    w = ad & 8'hFC;
    x.id = nid++;
    x.ad = ad;
    if (wr) begin
      x.e = wr_err(w, t);
      x.d = 32'd0;
      x.chk = 1'b0;
    end else begin
      rd_exp(w, t, x.d, x.e);
      x.chk = !x.e;
    end
    q.push_back(x);
    bus.PSEL = 1'b1;
    bus.PWRITE = wr;
    bus.PADDR = ad;
    bus.PWDATA = wd;
    bus.PENABLE = 1'b0;
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    n = 0;
    ok = 1'b1;
    forever begin
      @(negedge CLK);
      if (bus.PREADY) break;
      n++;
      if (n > 40) begin
        ok = 1'b0;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL apb_timeout addr=%h: PREADY=0 after %0d cycles, want 1",
               ad, n);
      void'(q.pop_back());
    end
    @(posedge CLK); #1;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    if (ok && wr && !x.e) m_write(w, wd, cyc);
  endtask

  task automatic idle(input int n);
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    m_reset();
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  task automatic wait_state(input int t);
    int n;
    n = 0;
    while (cyc < t && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  // Monitor: every completed transfer is compared with the queue head
  always @(negedge CLK) begin
    if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected addr=%h: no expectation queued",
                 bus.PADDR);
      end else begin
        mx = q.pop_front();
        if (bus.PSLVERR !== mx.e || (mx.chk && bus.PRDATA !== mx.d)) begin
          errors++;
          $display("FAIL apb#%0d addr=%h: got data=%h err=%b, want data=%h err=%b",
                   mx.id, mx.ad, bus.PRDATA, bus.PSLVERR, mx.d, mx.e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  rf;
    int r;
    m_reset();
    bus.PSEL = 0;
    bus.PENABLE = 0;
    bus.PWRITE = 0;
    bus.PADDR = 0;
    bus.PWDATA = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    @(negedge CLK);
    chk_bit("reset_pready", bus.PREADY, 1'b1);
    chk_bit("reset_pslverr", bus.PSLVERR, 1'b0);
    @(posedge CLK); #1;
    for (int i = 0; i <= 'h18; i += 4) apb(0, 8'(i), 0);

    apb(1, 8'h00, 7);
    apb(1, 8'h04, 5);
    apb(1, 8'h08, 0);
    apb(1, 8'h0C, 1);
    repeat (3) apb(0, 8'h10, 0);
    apb(0, 8'h14, 0);
    apb(1, 8'h08, 1);
    apb(1, 8'h0C, 1);
    idle(3);
    apb(0, 8'h10, 0);
    apb(0, 8'h14, 0);

    apb(1, 8'h00, 5);
    apb(1, 8'h04, 7);
    apb(1, 8'h08, 2);
    apb(1, 8'h0C, 1);
    apb(0, 8'h14, 0);

    apb(1, 8'h04, 0);
    apb(1, 8'h08, 3);
    apb(1, 8'h0C, 1);
    idle(3);
    apb(0, 8'h10, 0);
    apb(0, 8'h14, 0);
    apb(1, 8'h08, 32'hFFFF_FF20);
    apb(0, 8'h08, 0);
    apb(1, 8'h0C, 1);
    idle(3);
    apb(0, 8'h10, 0);
    apb(0, 8'h14, 0);
    apb(1, 8'h0C, 2);
    apb(0, 8'h10, 0);
    apb(1, 8'h08, 0);
    apb(1, 8'h0C, 3);
    apb(0, 8'h10, 0);
    idle(3);

    apb(1, 8'h00, 1);
    apb(1, 8'h04, 2);
    apb(1, 8'h0C, 1);
    apb(1, 8'h00, 9);
    apb(1, 8'h0C, 1);
    idle(4);
    apb(0, 8'h01, 0);
    apb(0, 8'h14, 0);
    apb(0, 8'h10, 0);
    apb(0, 8'h1C, 0);
    apb(1, 8'h10, 1);
    apb(1, 8'h14, 1);
    apb(0, 8'h0C, 0);

    apb(1, 8'h00, 40);
    apb(1, 8'h0C, 1);
    pulse_reset();
    apb(0, 8'h10, 0);
    apb(0, 8'h14, 0);
    idle(4);
    apb(0, 8'h10, 0);
    apb(0, 8'h14, 0);

`ifdef APB_ALU_CTRL_IRQ_EN
    apb(1, 8'h18, 1);
    apb(0, 8'h18, 0);
    apb(1, 8'h00, 3);
    apb(1, 8'h0C, 1);
    wait_state(m_l + LAT);
    @(negedge CLK);
    chk_bit("irq_at_capture", IRQ, 1'b0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk_bit("irq_after_capture", IRQ, 1'b1);
    @(posedge CLK); #1;
    apb(1, 8'h0C, 2);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk_bit("irq_after_clear", IRQ, 1'b0);
    @(posedge CLK); #1;
`else
    apb(1, 8'h18, 1);
`endif

    for (int k = 0; k < 30; k++) begin
      ra = $urandom;
      rb = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
      r = $urandom_range(0, 15);
      if (r <= 12) rf = 8'(r);
      else if (r == 13) begin
        rf = 8'h03;
        rb = 0;
      end else rf = 8'($urandom_range(13, 255));
      apb(1, 8'h00, ra);
      apb(1, 8'h04, rb);
      apb(1, 8'h08, {24'($urandom), rf});
      apb(1, 8'h0C, {30'd0, 1'($urandom), 1'b1});
      case ($urandom_range(0, 2))
        0: apb(0, 8'h14, 0);
        1: begin
          apb(1, 8'h04, $urandom);
          idle($urandom_range(0, 3));
          apb(0, 8'h10, 0);
          apb(0, 8'h14, 0);
        end
        default: begin
          idle($urandom_range(0, 4));
          apb(0, 8'h10, 0);
          apb(1, 8'h0C, 2);
          apb(0, 8'h10, 0);
          apb(0, 8'h14, 0);
        end
      endcase
    end

    idle(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
